board_render_scheduler: RTL

- Time-shares one tile renderer (block_vga_module-style: 4-bit tile state plus local h/v counts in, 12-bit pixel out) across the 16 cells of the 4x4 2048 board.
- Decodes the VGA scan position into a cell, local coordinates and that cell's state, and compensates the renderer's pipeline latency.
- Composes the final pixel: tile, board frame or background.
- Double-buffers board updates from game logic and commits them only at frame end, so no tearing.

---
 rtl/board_render_scheduler.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/board_render_scheduler.sv
// board_render_scheduler: shares one tile renderer across the 16 cells of a
// 4x4 board, decodes the scan position into cell/local coordinates, aligns
// the frame/background decision with the renderer latency and composes the
// final pixel. Board updates are double-buffered and committed at frame end.
// Optional feature macro: TILE_FLASH_EN (flash a white ring on changed tiles
// for 8 frames after each commit).
module board_render_scheduler #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned BOARD_X0    = 88,
  parameter int unsigned BOARD_Y0    = 8,
  parameter int unsigned TILE_SIZE   = 106,
  parameter int unsigned GAP         = 8,
  parameter int unsigned RENDER_LAT  = 2,
  parameter logic [11:0] BOARD_COLOR = 12'hBAA,
  parameter logic [11:0] BG_COLOR    = 12'hFEE,
  localparam int unsigned CW         = 12,
  localparam int unsigned BW         = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] h_cnt,
  input  logic [CW-1:0] v_cnt,
  input  logic [BW-1:0] board_in,
  input  logic          update_valid,
  output logic          update_ready,
  output logic          update_done,
  output logic [3:0]    tile_state,
  output logic [CW-1:0] tile_h_cnt,
  output logic [CW-1:0] tile_v_cnt,
  input  logic [CW-1:0] render_data,
  output logic [CW-1:0] vga_data
);

  localparam int unsigned PITCH  = TILE_SIZE + GAP;
  localparam int unsigned EXTENT = 4 * PITCH + GAP;

  logic [BW-1:0] pending_q;
  logic [BW-1:0] display_q;
  logic          commit_pt_c;

  logic          col_hit_c, row_hit_c;
  logic [1:0]    col_idx_c, row_idx_c;
  logic [CW-1:0] col_base_c, row_base_c;
  logic          in_tile_c, in_board_c, active_c;
  logic [3:0]    cell_idx_c;
  logic [CW-1:0] loc_h_c, loc_v_c;

  logic                  in_tile_s1, in_board_s1, active_s1;
  logic [RENDER_LAT-1:0] in_tile_d, in_board_d, active_d;
  logic [CW-1:0]         vga_next_c;

  assign commit_pt_c = (h_cnt == '0) && (v_cnt == CW'(V_ACTIVE));

  // Accept handshake into the pending buffer and frame-end commit to display.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      display_q    <= '0;
      update_ready <= 1'b1;
      update_done  <= 1'b0;
    end else begin
      update_done <= 1'b0;
      if (update_valid && update_ready) begin
        pending_q    <= board_in;
        update_ready <= 1'b0;
      end else if (commit_pt_c && !update_ready) begin
        display_q    <= pending_q;
        update_ready <= 1'b1;
        update_done  <= 1'b1;
      end
    end
  end

  // Constant-comparator decode of scan position into cell and local counts.
  always_comb begin
    col_hit_c  = 1'b0;
    row_hit_c  = 1'b0;
    col_idx_c  = '0;
    row_idx_c  = '0;
    col_base_c = '0;
    row_base_c = '0;
    for (int i = 0; i < 4; i++) begin
      if (h_cnt >= CW'(BOARD_X0 + GAP + i * PITCH) &&
          h_cnt <= CW'(BOARD_X0 + GAP + i * PITCH + TILE_SIZE - 1)) begin
        col_hit_c  = 1'b1;
        col_idx_c  = 2'(i);
        col_base_c = CW'(BOARD_X0 + GAP + i * PITCH);
      end
      if (v_cnt >= CW'(BOARD_Y0 + GAP + i * PITCH) &&
          v_cnt <= CW'(BOARD_Y0 + GAP + i * PITCH + TILE_SIZE - 1)) begin
        row_hit_c  = 1'b1;
        row_idx_c  = 2'(i);
        row_base_c = CW'(BOARD_Y0 + GAP + i * PITCH);
      end
    end
    in_tile_c  = col_hit_c && row_hit_c;
    in_board_c = (h_cnt >= CW'(BOARD_X0)) && (h_cnt <= CW'(BOARD_X0 + EXTENT - 1)) &&
                 (v_cnt >= CW'(BOARD_Y0)) && (v_cnt <= CW'(BOARD_Y0 + EXTENT - 1));
    active_c   = (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
    cell_idx_c = {row_idx_c, col_idx_c};
    loc_h_c    = h_cnt - col_base_c;
    loc_v_c    = v_cnt - row_base_c;
  end

  // Stage 1: registered renderer inputs and pixel classification.
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_state  <= '0;
      tile_h_cnt  <= '0;
      tile_v_cnt  <= '0;
      in_tile_s1  <= 1'b0;
      in_board_s1 <= 1'b0;
      active_s1   <= 1'b0;
    end else begin
      tile_state  <= in_tile_c ? display_q[{cell_idx_c, 2'b00} +: 4] : 4'd0;
      tile_h_cnt  <= in_tile_c ? loc_h_c : '0;
      tile_v_cnt  <= in_tile_c ? loc_v_c : '0;
      in_tile_s1  <= in_tile_c;
      in_board_s1 <= in_board_c;
      active_s1   <= active_c;
    end
  end

  // Delay classification flags to line up with render_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_tile_d  <= '0;
      in_board_d <= '0;
      active_d   <= '0;
    end else begin
      in_tile_d[0]  <= in_tile_s1;
      in_board_d[0] <= in_board_s1;
      active_d[0]   <= active_s1;
      for (int i = 1; i < int'(RENDER_LAT); i++) begin
        in_tile_d[i]  <= in_tile_d[i-1];
        in_board_d[i] <= in_board_d[i-1];
        active_d[i]   <= active_d[i-1];
      end
    end
  end

`ifdef TILE_FLASH_EN
  logic [15:0]           flash_mask_q;
  logic [3:0]            flash_cnt_q;
  logic [15:0]           diff_c;
  logic                  ring_c;
  logic                  ring_s1;
  logic [RENDER_LAT-1:0] ring_d;

  // Cells whose value changes at the next commit, and ring-pixel detection.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      diff_c[i] = display_q[4*i +: 4] != pending_q[4*i +: 4];
    end
    ring_c = in_tile_c && flash_mask_q[cell_idx_c] &&
             (loc_h_c <= CW'(3) || loc_h_c >= CW'(TILE_SIZE - 4) ||
              loc_v_c <= CW'(3) || loc_v_c >= CW'(TILE_SIZE - 4));
  end

  // Flash mask and frame countdown, stepped at every frame-end point.
  always_ff @(posedge clk) begin
    if (rst) begin
      flash_mask_q <= '0;
      flash_cnt_q  <= '0;
    end else if (commit_pt_c) begin
      if (!update_ready) begin
        flash_mask_q <= diff_c;
        flash_cnt_q  <= 4'd8;
      end else if (flash_cnt_q != 4'd0) begin
        flash_cnt_q <= flash_cnt_q - 4'd1;
        if (flash_cnt_q == 4'd1) flash_mask_q <= '0;
      end
    end
  end

  // Ring decision travels alongside the other classification flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_s1 <= 1'b0;
      ring_d  <= '0;
    end else begin
      ring_s1   <= ring_c;
      ring_d[0] <= ring_s1;
      for (int i = 1; i < int'(RENDER_LAT); i++) ring_d[i] <= ring_d[i-1];
    end
  end
`endif

  // Final pixel selection: blank, tile, frame, background.
  always_comb begin
    vga_next_c = BG_COLOR;
    if (!active_d[RENDER_LAT-1]) begin
      vga_next_c = '0;
    end else if (in_tile_d[RENDER_LAT-1]) begin
`ifdef TILE_FLASH_EN
      vga_next_c = ring_d[RENDER_LAT-1] ? 12'hFFF : render_data;
`else
      vga_next_c = render_data;
`endif
    end else if (in_board_d[RENDER_LAT-1]) begin
      vga_next_c = BOARD_COLOR;
    end
  end

  // Registered pixel output.
  always_ff @(posedge clk) begin
    if (rst) vga_data <= '0;
    else     vga_data <= vga_next_c;
  end

endmodule
